// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command in, one AXI burst out, byte streams on the data side.
// Optional handshake watchdog enabled by defining AXI_MST_TIMEOUT_EN.
module axi_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [3:0]            r_beat_cnt;
    logic [1:0]            r_resp;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_at_last;
    logic w_timeout;

    assign w_cmd_hs  = cmd_valid && r_cmd_ready;
    assign w_aw_hs   = (r_state == S_AW) && awready;
    assign w_w_hs    = (r_state == S_W) && wr_valid && wready;
    assign w_b_hs    = (r_state == S_B) && bvalid;
    assign w_ar_hs   = (r_state == S_AR) && arready;
    assign w_r_hs    = (r_state == S_R) && rvalid && rd_ready;
    assign w_at_last = (r_beat_cnt == r_len);

    // Address channels are driven from state only, so valid never waits on ready.
    assign cmd_ready = r_cmd_ready;
    assign awvalid   = (r_state == S_AW);
    assign arvalid   = (r_state == S_AR);
    assign awaddr    = r_addr;
    assign awlen     = r_len;
    assign awsize    = r_size;
    assign awburst   = r_burst;
    assign araddr    = r_addr;
    assign arlen     = r_len;
    assign arsize    = r_size;
    assign arburst   = r_burst;

    assign wvalid    = (r_state == S_W) && wr_valid;
    assign wdata     = wr_data;
    assign wlast     = (r_state == S_W) && w_at_last;
    assign wr_ready  = (r_state == S_W) && wready;
    assign bready    = (r_state == S_B);

    assign rd_valid  = (r_state == S_R) && rvalid;
    assign rd_data   = rdata;
    assign rd_last   = (r_state == S_R) && rlast;
    assign rready    = (r_state == S_R) && rd_ready;

    assign done      = (r_state == S_DONE);
    assign done_resp = r_resp;

`ifdef AXI_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          w_busy;
    logic          w_any_hs;

    assign w_busy    = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B) ||
                       (r_state == S_AR) || (r_state == S_R);
    assign w_any_hs  = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
    assign w_timeout = w_busy && !w_any_hs && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_busy || w_any_hs) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    // Watchdog absent: a positive limit never trips.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (cmd_size > 3'd3) begin
                        w_state_next = S_DONE;
                    end else if (cmd_write) begin
                        w_state_next = S_AW;
                    end else begin
                        w_state_next = S_AR;
                    end
                end
            end
            S_AW:    if (w_aw_hs) w_state_next = S_W;
            S_W:     if (w_w_hs && w_at_last) w_state_next = S_B;
            S_B:     if (w_b_hs) w_state_next = S_DONE;
            S_AR:    if (w_ar_hs) w_state_next = S_R;
            S_R:     if (w_r_hs && rlast) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_resp      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == S_IDLE);
            if (w_cmd_hs) begin
                r_addr     <= cmd_addr;
                r_len      <= cmd_len;
                r_size     <= cmd_size;
                r_burst    <= cmd_burst;
                r_beat_cnt <= '0;
                r_resp     <= (cmd_size > 3'd3) ? 2'b10 : 2'b00;
            end
            if (w_w_hs || w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
            if (w_b_hs) begin
                r_resp <= bresp;
            end
            // Error sticks on a bad rresp, an early rlast, or a beat at len without rlast.
            if (w_r_hs && ((rresp != 2'b00) || (rlast != w_at_last))) begin
                r_resp <= 2'b10;
            end
            if (w_timeout) begin
                r_resp <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: command table plus hand-written flow-control and reset sequences.
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [7:0]  wdata;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [7:0]  rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  data0;      // expected byte on beat 0, then +1 per beat
        int          last_beat;  // read: beat index on which the slave raises rlast
        int          err_beat;   // read: beat index carrying rresp=10 (-1 none)
        logic [1:0]  bresp;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0; arready = 1'b0;
        rdata = '0; rresp = '0; rvalid = 1'b0; rlast = 1'b0;
    endtask

    // Accept a command and complete its address handshake; ok=0 if nothing more should follow.
    task automatic issue_cmd(input vec_t v, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready === 1'b1) break;
            @(negedge clk);
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        cmd_size = v.size; cmd_burst = v.burst;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (v.size > 3'd3) begin
            chk("badsize_awvalid", {63'd0, awvalid}, 64'd0);
            chk("badsize_arvalid", {63'd0, arvalid}, 64'd0);
            chk("badsize_done", {63'd0, done}, 64'd1);
            chk("badsize_resp", {62'd0, done_resp}, {62'd0, v.exp_resp});
            return;
        end
        if (v.wr) begin
            chk("awvalid", {63'd0, awvalid}, 64'd1);
            chk("arvalid_quiet", {63'd0, arvalid}, 64'd0);
            chk("awaddr", {32'd0, awaddr}, {32'd0, v.addr});
            chk("awlen", {60'd0, awlen}, {60'd0, v.len});
            chk("awsize", {61'd0, awsize}, {61'd0, v.size});
            chk("awburst", {62'd0, awburst}, {62'd0, v.burst});
            awready = 1'b1;
        end else begin
            chk("arvalid", {63'd0, arvalid}, 64'd1);
            chk("awvalid_quiet", {63'd0, awvalid}, 64'd0);
            chk("araddr", {32'd0, araddr}, {32'd0, v.addr});
            chk("arlen", {60'd0, arlen}, {60'd0, v.len});
            chk("arsize", {61'd0, arsize}, {61'd0, v.size});
            chk("arburst", {62'd0, arburst}, {62'd0, v.burst});
            arready = 1'b1;
        end
        @(negedge clk);
        awready = 1'b0; arready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic finish_txn(input vec_t v, input int id);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_resp", {62'd0, done_resp}, {62'd0, v.exp_resp});
        $display("txn %0d: %s addr=%h len=%0d size=%0d resp=%b", id, v.wr ? "WR" : "RD",
                 v.addr, v.len, v.size, done_resp);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        bit         ok;
        logic [7:0] idx;
        issue_cmd(v, ok);
        if (!ok) begin
            if (v.size > 3'd3) finish_txn(v, id);
            return;
        end
        if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                wr_data = v.data0 + 8'(i); wr_valid = 1'b1; wready = 1'b1;
                #1;
                chk("wvalid", {63'd0, wvalid}, 64'd1);
                chk("wdata", {56'd0, wdata}, {56'd0, v.data0 + 8'(i)});
                chk("wlast", {63'd0, wlast}, {63'd0, i == int'(v.len)});
                chk("wr_ready", {63'd0, wr_ready}, 64'd1);
                idx = v.addr[7:0] + 8'(i);
                mem[idx] = wr_data;
                @(negedge clk);
            end
            wr_valid = 1'b0; wready = 1'b0;
            #1;
            chk("bready", {63'd0, bready}, 64'd1);
            chk("wr_ready_in_b", {63'd0, wr_ready}, 64'd0);
            bvalid = 1'b1; bresp = v.bresp;
            @(negedge clk);
            bvalid = 1'b0; bresp = 2'b00;
        end else begin
            for (int i = 0; i <= v.last_beat; i++) begin
                idx = v.addr[7:0] + 8'(i);
                rvalid = 1'b1; rdata = mem[idx]; rlast = (i == v.last_beat);
                rresp = (i == v.err_beat) ? 2'b10 : 2'b00; rd_ready = 1'b1;
                #1;
                chk("rd_valid", {63'd0, rd_valid}, 64'd1);
                chk("rd_data", {56'd0, rd_data}, {56'd0, v.data0 + 8'(i)});
                chk("rd_last", {63'd0, rd_last}, {63'd0, i == v.last_beat});
                chk("rready", {63'd0, rready}, 64'd1);
                @(negedge clk);
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
        end
        finish_txn(v, id);
    endtask

    initial begin
        vec_t       v;
        bit         ok;
        logic [3:0] pat;
        int         beat;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        //            wr    addr      len   size  burst  data0  last err  bresp  exp
        vecs[0] = '{1'b1, 32'h10, 4'd3, 3'd0, 2'b01, 8'hA0, 0,  -1, 2'b00, 2'b00};
        vecs[1] = '{1'b0, 32'h10, 4'd3, 3'd0, 2'b01, 8'hA0, 3,  -1, 2'b00, 2'b00};
        vecs[2] = '{1'b1, 32'h40, 4'd0, 3'd4, 2'b01, 8'h00, 0,  -1, 2'b00, 2'b10};
        vecs[3] = '{1'b0, 32'h10, 4'd3, 3'd0, 2'b01, 8'hA0, 1,  -1, 2'b00, 2'b10};
        vecs[4] = '{1'b1, 32'h20, 4'd0, 3'd2, 2'b11, 8'h55, 0,  -1, 2'b10, 2'b10};
        vecs[5] = '{1'b0, 32'h20, 4'd0, 3'd2, 2'b10, 8'h55, 0,   0, 2'b00, 2'b10};
        vecs[6] = '{1'b0, 32'h10, 4'd1, 3'd0, 2'b00, 8'hA0, 2,  -1, 2'b00, 2'b10};
        vecs[7] = '{1'b0, 32'h10, 4'd0, 3'd5, 2'b01, 8'h00, 0,  -1, 2'b00, 2'b10};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_done_resp", {62'd0, done_resp}, 64'd0);
        chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_awaddr", {32'd0, awaddr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Read len=1 with rd_ready pattern 1,0,0,1: beats advance only on handshake.
        v = '{1'b0, 32'h12, 4'd1, 3'd0, 2'b01, 8'hA2, 1, -1, 2'b00, 2'b00};
        issue_cmd(v, ok);
        if (ok) begin
            pat  = 4'b1001;
            beat = 0;
            for (int c = 0; c < 4; c++) begin
                rvalid = 1'b1; rdata = mem[8'h12 + 8'(beat)]; rlast = (beat == 1);
                rd_ready = pat[3 - c];
                #1;
                chk("toggle_rready", {63'd0, rready}, {63'd0, pat[3 - c]});
                chk("toggle_rd_valid", {63'd0, rd_valid}, 64'd1);
                chk("toggle_rd_data", {56'd0, rd_data}, {56'd0, 8'hA2 + 8'(beat)});
                chk("toggle_no_early_done", {63'd0, done}, 64'd0);
                @(negedge clk);
                if (pat[3 - c]) beat++;
            end
            rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
            finish_txn(v, 8);
        end

        // Reset while the second W beat is on the bus.
        v = '{1'b1, 32'h30, 4'd3, 3'd0, 2'b01, 8'hB0, 0, -1, 2'b00, 2'b00};
        issue_cmd(v, ok);
        if (ok) begin
            wr_data = 8'hB0; wr_valid = 1'b1; wready = 1'b1;
            @(negedge clk);
            wr_data = 8'hB1; rst = 1'b1;
            @(negedge clk);
            chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            chk("mid_rst_done", {63'd0, done}, 64'd0);
            chk("mid_rst_done_resp", {62'd0, done_resp}, 64'd0);
            chk("mid_rst_awvalid", {63'd0, awvalid}, 64'd0);
            chk("mid_rst_awaddr", {32'd0, awaddr}, 64'd0);
            chk("mid_rst_awlen", {60'd0, awlen}, 64'd0);
            chk("mid_rst_wvalid", {63'd0, wvalid}, 64'd0);
            chk("mid_rst_wlast", {63'd0, wlast}, 64'd0);
            chk("mid_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
            chk("mid_rst_bready", {63'd0, bready}, 64'd0);
            chk("mid_rst_rready", {63'd0, rready}, 64'd0);
            chk("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
            rst = 1'b0; wr_valid = 1'b0; wready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("mid_rst_no_done", {63'd0, done}, 64'd0);
            end
            $display("txn 9: WR addr=%h abandoned by reset", v.addr);
        end
        v = '{1'b0, 32'h10, 4'd0, 3'd0, 2'b01, 8'hA0, 0, -1, 2'b00, 2'b00};
        run_vec(v, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
